// File: rtl/anton_product_sched.sv
// Arbitrates two requesters onto one shared nibble multiplier: loads A then B,
// strobes read, captures the 8-bit product and returns it with the requester id.
module anton_product_sched #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [1:0] req_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_product,
  output logic       busy,
  output logic [7:0] done_count,
  output logic [3:0] mul_nibble,
  output logic       mul_read,
  input  logic [7:0] mul_result
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    READ   = 3'd3,
    CAPT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] op_a, op_b;
  logic       op_id;
  logic       last_grant;
  logic       grant;
  logic       accept;

  // Round-robin only matters on contention; otherwise requester 0 wins if valid.
  always_comb begin
    grant = ~req_valid[0];
    if (ROUND_ROBIN && (&req_valid)) grant = ~last_grant;
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && req_valid[grant]) req_ready[grant] = 1'b1;
  end

  assign accept = |req_ready;

  always_comb begin
    state_nxt  = state;
    mul_nibble = 4'd0;
    mul_read   = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD_A;
      LOAD_A:  begin
        mul_nibble = op_a;
        state_nxt  = LOAD_B;
      end
      LOAD_B:  begin
        mul_nibble = op_b;
        state_nxt  = READ;
      end
      READ:    begin
        mul_read  = 1'b1;
        state_nxt = CAPT;
      end
      CAPT:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op_a         <= 4'd0;
      op_b         <= 4'd0;
      op_id        <= 1'b0;
      last_grant   <= 1'b1;
      resp_valid   <= 1'b0;
      resp_product <= 8'd0;
      done_count   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        op_a       <= grant ? req_a[7:4] : req_a[3:0];
        op_b       <= grant ? req_b[7:4] : req_b[3:0];
        op_id      <= grant;
        last_grant <= grant;
      end
      if (state == CAPT) begin
        resp_product <= mul_result;
        resp_valid   <= 1'b1;
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        done_count <= done_count + 8'd1;
      end
    end
  end

  assign resp_id = op_id;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_anton_product_sched.sv
// Directed bench: two schedulers (round-robin and fixed priority) share stimulus,
// each driving its own behavioural nibble multiplier.
module tb_anton_product_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_a, req_b;
  logic       resp_ready;

  logic [1:0] rr_req_ready, fp_req_ready;
  logic       rr_resp_valid, fp_resp_valid;
  logic       rr_resp_id, fp_resp_id;
  logic [7:0] rr_resp_product, fp_resp_product;
  logic       rr_busy, fp_busy;
  logic [7:0] rr_done_count, fp_done_count;
  logic [3:0] rr_mul_nibble, fp_mul_nibble;
  logic       rr_mul_read, fp_mul_read;
  logic [7:0] rr_mreg = 8'd0, fp_mreg = 8'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  anton_product_sched #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rr_req_ready), .resp_valid(rr_resp_valid), .resp_ready(resp_ready),
    .resp_id(rr_resp_id), .resp_product(rr_resp_product), .busy(rr_busy),
    .done_count(rr_done_count), .mul_nibble(rr_mul_nibble), .mul_read(rr_mul_read),
    .mul_result(rr_mreg)
  );

  anton_product_sched #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(fp_req_ready), .resp_valid(fp_resp_valid), .resp_ready(resp_ready),
    .resp_id(fp_resp_id), .resp_product(fp_resp_product), .busy(fp_busy),
    .done_count(fp_done_count), .mul_nibble(fp_mul_nibble), .mul_read(fp_mul_read),
    .mul_result(fp_mreg)
  );

  // Shared-datapath model: shift a nibble in each cycle, or replace with hi*lo on read.
  always @(posedge clk) begin
    if (rr_mul_read) rr_mreg <= rr_mreg[7:4] * rr_mreg[3:0];
    else             rr_mreg <= {rr_mreg[3:0], rr_mul_nibble};
    if (fp_mul_read) fp_mreg <= fp_mreg[7:4] * fp_mreg[3:0];
    else             fp_mreg <= {fp_mreg[3:0], fp_mul_nibble};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete op on both instances starting from IDLE with inputs already set;
  // resp_ready must be high. Ends one cycle after RESP, back in IDLE.
  task automatic run_op(input logic [1:0] rr_grant, input logic [3:0] rr_a, input logic [3:0] rr_b,
                        input logic [7:0] rr_prod, input logic [1:0] fp_grant,
                        input logic [7:0] fp_prod);
    chk("rr_req_ready", rr_req_ready, rr_grant);
    chk("fp_req_ready", fp_req_ready, fp_grant);
    tick();
    chk("rr_load_a_nib", rr_mul_nibble, rr_a);
    chk("rr_load_a_rd", rr_mul_read, 1'b0);
    chk("rr_busy_a", rr_busy, 1'b1);
    chk("rr_ready_busy", rr_req_ready, 2'b00);
    tick();
    chk("rr_load_b_nib", rr_mul_nibble, rr_b);
    chk("rr_load_b_rd", rr_mul_read, 1'b0);
    tick();
    chk("rr_read_nib", rr_mul_nibble, 4'd0);
    chk("rr_read_rd", rr_mul_read, 1'b1);
    tick();
    chk("rr_capt_valid", rr_resp_valid, 1'b0);
    chk("rr_capt_rd", rr_mul_read, 1'b0);
    chk("rr_capt_busy", rr_busy, 1'b1);
    tick();
    chk("rr_resp_valid", rr_resp_valid, 1'b1);
    chk("rr_resp_product", rr_resp_product, rr_prod);
    chk("rr_resp_id", rr_resp_id, rr_grant[1]);
    chk("fp_resp_valid", fp_resp_valid, 1'b1);
    chk("fp_resp_product", fp_resp_product, fp_prod);
    chk("fp_resp_id", fp_resp_id, fp_grant[1]);
    tick();
    chk("rr_idle_valid", rr_resp_valid, 1'b0);
    chk("rr_idle_busy", rr_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_a = 8'h00; req_b = 8'h00; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", rr_busy, 1'b0);
    chk("rst_valid", rr_resp_valid, 1'b0);
    chk("rst_id", rr_resp_id, 1'b0);
    chk("rst_product", rr_resp_product, 8'd0);
    chk("rst_done", rr_done_count, 8'd0);
    chk("rst_ready_idle", rr_req_ready, 2'b00);
    reset = 1'b0;
    tick();

    // Single op 3x5 from requester 0; operands change after accept and must be ignored.
    req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05; resp_ready = 1'b1;
    #1;
    chk("t1_ready", rr_req_ready, 2'b01);
    tick();
    req_valid = 2'b00; req_a = 8'h0F; req_b = 8'h0F;
    chk("t1_nib_a", rr_mul_nibble, 4'd3);
    chk("t1_ready_drop", rr_req_ready, 2'b00);
    tick();
    chk("t1_nib_b", rr_mul_nibble, 4'd5);
    tick();
    chk("t1_read", rr_mul_read, 1'b1);
    tick();
    chk("t1_capt_valid", rr_resp_valid, 1'b0);
    tick();
    chk("t1_valid", rr_resp_valid, 1'b1);
    chk("t1_product", rr_resp_product, 8'd15);
    chk("t1_id", rr_resp_id, 1'b0);
    tick();
    chk("t1_done", rr_done_count, 8'd1);
    chk("t1_valid_drop", rr_resp_valid, 1'b0);

    // Contention: r0 15x15, r1 7x9; RR alternates from 0, FP always picks 0.
    reset = 1'b1; #1; reset = 1'b0;
    req_valid = 2'b11; req_a = 8'h7F; req_b = 8'h9F; resp_ready = 1'b1;
    #1;
    run_op(2'b01, 4'd15, 4'd15, 8'd225, 2'b01, 8'd225);
    run_op(2'b10, 4'd7,  4'd9,  8'd63,  2'b01, 8'd225);
    run_op(2'b01, 4'd15, 4'd15, 8'd225, 2'b01, 8'd225);
    run_op(2'b10, 4'd7,  4'd9,  8'd63,  2'b01, 8'd225);
    chk("t2_rr_done", rr_done_count, 8'd4);
    chk("t2_fp_done", fp_done_count, 8'd4);

    // Only requester 1 valid: fixed priority must still grant it.
    req_valid = 2'b10; req_a = 8'h20; req_b = 8'h30;
    #1;
    run_op(2'b10, 4'd2, 4'd3, 8'd6, 2'b10, 8'd6);

    // Backpressure: resp_ready low for 10 cycles in RESP with r0 still requesting.
    req_valid = 2'b01; req_a = 8'h04; req_b = 8'h06; resp_ready = 1'b0;
    #1;
    chk("t3_ready", rr_req_ready, 2'b01);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", rr_resp_valid, 1'b1);
      chk("t3_hold_product", rr_resp_product, 8'd24);
      chk("t3_hold_id", rr_resp_id, 1'b0);
      chk("t3_hold_ready", rr_req_ready, 2'b00);
      chk("t3_hold_done", rr_done_count, 8'd5);
      tick();
    end
    req_valid = 2'b00; resp_ready = 1'b1;
    tick();
    chk("t3_done", rr_done_count, 8'd6);
    chk("t3_valid_drop", rr_resp_valid, 1'b0);
    tick();
    chk("t3_done_once", rr_done_count, 8'd6);

    // Reset landing in LOAD_B, then recovery ops 0x12 and 12x1.
    req_valid = 2'b01; req_a = 8'h09; req_b = 8'h09;
    tick(); tick();
    chk("t4_in_load_b", rr_mul_nibble, 4'd9);
    reset = 1'b1;
    #1;
    chk("t4_busy", rr_busy, 1'b0);
    chk("t4_valid", rr_resp_valid, 1'b0);
    chk("t4_done", rr_done_count, 8'd0);
    tick();
    reset = 1'b0; req_a = 8'h00; req_b = 8'h0C;
    #1;
    run_op(2'b01, 4'd0, 4'd12, 8'd0, 2'b01, 8'd0);
    req_a = 8'h0C; req_b = 8'h01;
    #1;
    run_op(2'b01, 4'd12, 4'd1, 8'd12, 2'b01, 8'd12);
    chk("t4_done_after", rr_done_count, 8'd2);

    // 256 back-to-back ops covering every operand pair; done_count wraps to 0.
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      a = i[3:0];
      b = i[7:4];
      req_a = {4'd0, a}; req_b = {4'd0, b};
      #1;
      if (i == 255) chk("t5_done_255", rr_done_count, 8'd255);
      run_op(2'b01, a, b, 8'(a * b), 2'b01, 8'(a * b));
    end
    chk("t5_wrap", rr_done_count, 8'd0);
    chk("t5_fp_wrap", fp_done_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
